// File: rtl/code_loader.sv
// Byte-stream program loader: receives COUNT, N word pairs and an XOR checksum,
// writes the words into the code memory user region and holds the CPU meanwhile.
module code_loader #(
    parameter int BASE_ADDR = 32,
    parameter int MAX_WORDS = 32,
    parameter int TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        mem_we,
    output logic [5:0]  mem_waddr,
    output logic [15:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [5:0]  words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_HI    = 3'd2,
        S_LO    = 3'd3,
        S_CSUM  = 3'd4,
        S_DONE  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    localparam logic [5:0]  BASE_W   = 6'(BASE_ADDR);
    localparam logic [7:0]  MAX_W    = 8'(MAX_WORDS);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

    localparam logic [1:0]  ERR_NONE  = 2'b00;
    localparam logic [1:0]  ERR_COUNT = 2'b01;
    localparam logic [1:0]  ERR_CSUM  = 2'b10;
    localparam logic [1:0]  ERR_TOUT  = 2'b11;

    state_t       state_q, state_d;
    logic [6:0]   count_q;
    logic [7:0]   hi_q;
    logic [7:0]   xor_q;
    logic [15:0]  to_cnt_q;
    logic [5:0]   words_q;
    logic         we_q;
    logic [5:0]   waddr_q;
    logic [15:0]  wdata_q;
    logic         hold_q;
    logic [1:0]   err_code_q;

    logic         active_s;
    logic         accept_s;
    logic         timeout_s;
    logic         start_go_s;
    logic         count_bad_s;
    logic         last_word_s;
    logic         csum_ok_s;

    always_comb begin
        active_s    = (state_q == S_COUNT) || (state_q == S_HI) ||
                      (state_q == S_LO)    || (state_q == S_CSUM);
        accept_s    = active_s && rx_valid;
        // An accept in the expiry cycle resets the counter instead of aborting.
        timeout_s   = active_s && !rx_valid && (to_cnt_q == TO_LAST);
        start_go_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                (state_q == S_ERR));
        count_bad_s = (rx_data == 8'd0) || (rx_data > MAX_W);
        last_word_s = (({1'b0, words_q} + 7'd1) == count_q);
        csum_ok_s   = (rx_data == xor_q);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_go_s) state_d = S_COUNT;
                else            state_d = state_q;
            end
            S_COUNT: begin
                if (accept_s)       state_d = count_bad_s ? S_ERR : S_HI;
                else if (timeout_s) state_d = S_ERR;
                else                state_d = state_q;
            end
            S_HI: begin
                if (accept_s)       state_d = S_LO;
                else if (timeout_s) state_d = S_ERR;
                else                state_d = state_q;
            end
            S_LO: begin
                if (accept_s)       state_d = last_word_s ? S_CSUM : S_HI;
                else if (timeout_s) state_d = S_ERR;
                else                state_d = state_q;
            end
            S_CSUM: begin
                if (accept_s)       state_d = csum_ok_s ? S_DONE : S_ERR;
                else if (timeout_s) state_d = S_ERR;
                else                state_d = state_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state register.
    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state_q)
            S_COUNT, S_HI, S_LO, S_CSUM: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DONE:  done  = 1'b1;
            S_ERR:   error = 1'b1;
            default: begin
                rx_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    // Datapath: byte capture, checksum, timeout counter and memory write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= 7'd0;
            hi_q       <= 8'd0;
            xor_q      <= 8'd0;
            to_cnt_q   <= 16'd0;
            words_q    <= 6'd0;
            we_q       <= 1'b0;
            waddr_q    <= BASE_W;
            wdata_q    <= 16'd0;
            hold_q     <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            we_q <= 1'b0;
            if (start_go_s) begin
                words_q    <= 6'd0;
                xor_q      <= 8'd0;
                to_cnt_q   <= 16'd0;
                err_code_q <= ERR_NONE;
                hold_q     <= 1'b1;
            end else if (accept_s) begin
                to_cnt_q <= 16'd0;
                case (state_q)
                    S_COUNT: begin
                        if (count_bad_s) begin
                            err_code_q <= ERR_COUNT;
                        end else begin
                            count_q <= rx_data[6:0];
                            xor_q   <= rx_data;
                        end
                    end
                    S_HI: begin
                        hi_q  <= rx_data;
                        xor_q <= xor_q ^ rx_data;
                    end
                    S_LO: begin
                        we_q    <= 1'b1;
                        waddr_q <= BASE_W + words_q;
                        wdata_q <= {hi_q, rx_data};
                        words_q <= words_q + 6'd1;
                        xor_q   <= xor_q ^ rx_data;
                    end
                    S_CSUM: begin
                        if (csum_ok_s) hold_q     <= 1'b0;
                        else           err_code_q <= ERR_CSUM;
                    end
                    default: to_cnt_q <= 16'd0;
                endcase
            end else if (timeout_s) begin
                err_code_q <= ERR_TOUT;
            end else if (active_s) begin
                to_cnt_q <= to_cnt_q + 16'd1;
            end else begin
                to_cnt_q <= to_cnt_q;
            end
        end
    end

    assign mem_we       = we_q;
    assign mem_waddr    = waddr_q;
    assign mem_wdata    = wdata_q;
    assign cpu_hold     = hold_q;
    assign err_code     = err_code_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_code_loader.sv
// Randomized bench for code_loader: streams are built from the format rules and the
// expected writes and final status are derived from the stream contents.
module tb_code_loader;

    localparam int BASE = 32;
    localparam int MAXW = 32;
    localparam int TOUT = 16;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst, start, rx_valid, rx_ready;
    logic [7:0]  rx_data;
    logic        mem_we, cpu_hold, busy, done, error;
    logic [5:0]  mem_waddr, words_loaded;
    logic [15:0] mem_wdata;
    logic [1:0]  err_code;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [5:0]  last_addr;
    logic [15:0] last_data;

    code_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bq_t make_stream(input int n, input bit corrupt);
        bq_t s;
        logic [7:0] x;
        logic [7:0] b;
        s.push_back(8'(n));
        x = 8'(n);
        for (int i = 0; i < 2 * n; i++) begin
            b = 8'($urandom_range(0, 255));
            s.push_back(b);
            x = x ^ b;
        end
        if (corrupt) x = x ^ 8'(1 << $urandom_range(0, 7));
        s.push_back(x);
        return s;
    endfunction

    task automatic check_no_write(input string tag);
        check_eq({tag, " mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, " waddr hold"}, 32'(mem_waddr), 32'(last_addr));
        check_eq({tag, " wdata hold"}, 32'(mem_wdata), 32'(last_data));
    endtask

    task automatic check_reset();
        check_eq("rst rx_ready", 32'(rx_ready), 32'd0);
        check_eq("rst mem_we", 32'(mem_we), 32'd0);
        check_eq("rst mem_waddr", 32'(mem_waddr), 32'(BASE));
        check_eq("rst mem_wdata", 32'(mem_wdata), 32'd0);
        check_eq("rst cpu_hold", 32'(cpu_hold), 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst done", 32'(done), 32'd0);
        check_eq("rst error", 32'(error), 32'd0);
        check_eq("rst err_code", 32'(err_code), 32'd0);
        check_eq("rst words", 32'(words_loaded), 32'd0);
        last_addr = 6'(BASE);
        last_data = 16'd0;
    endtask

    task automatic start_load();
        start = 1'b1;
        step();
        start = 1'b0;
        check_eq("start busy", 32'(busy), 32'd1);
        check_eq("start hold", 32'(cpu_hold), 32'd1);
        check_eq("start done", 32'(done), 32'd0);
        check_eq("start error", 32'(error), 32'd0);
        check_eq("start err_code", 32'(err_code), 32'd0);
        check_eq("start words", 32'(words_loaded), 32'd0);
    endtask

    task automatic drive_byte(input logic [7:0] b, input bit poke, input bit exp_we,
                              input logic [5:0] ea, input logic [15:0] ed, input int ewl);
        check_eq("rx_ready", 32'(rx_ready), 32'd1);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        step();
        rx_valid = 1'b0;
        start    = 1'b0;
        if (exp_we) begin
            check_eq("write we", 32'(mem_we), 32'd1);
            check_eq("write addr", 32'(mem_waddr), 32'(ea));
            check_eq("write data", 32'(mem_wdata), 32'(ed));
            check_eq("write words", 32'(words_loaded), 32'(ewl));
            last_addr = ea;
            last_data = ed;
        end else begin
            check_no_write("byte");
        end
    endtask

    // Streams one image; stop_after >= 0 abandons it after that many bytes.
    task automatic send_stream(input bq_t s, input int max_gap, input bit poke, input int stop_after);
        int n;
        bit valid, ok, is_lo;
        int wi;
        logic [7:0] x;
        n = int'(s[0]);
        valid = (n != 0) && (n <= MAXW);
        x = 8'd0;
        if (valid) for (int j = 0; j <= 2 * n; j++) x = x ^ s[j];
        for (int k = 0; k < s.size(); k++) begin
            if (stop_after >= 0 && k == stop_after) return;
            repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) begin
                start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
                step();
                start = 1'b0;
                check_no_write("gap");
            end
            is_lo = valid && (k >= 2) && (k % 2 == 0) && (k <= 2 * n);
            wi = k / 2 - 1;
            if (is_lo)
                drive_byte(s[k], poke, 1'b1, 6'(BASE + wi), {s[k-1], s[k]}, wi + 1);
            else
                drive_byte(s[k], poke, 1'b0, 6'd0, 16'd0, 0);
        end
        ok = valid && (s[2 * n + 1] == x);
        check_eq("end done", 32'(done), 32'(ok));
        check_eq("end error", 32'(error), 32'(!ok));
        check_eq("end err_code", 32'(err_code), ok ? 32'd0 : (valid ? 32'd2 : 32'd1));
        check_eq("end hold", 32'(cpu_hold), 32'(!ok));
        check_eq("end busy", 32'(busy), 32'd0);
        check_eq("end rx_ready", 32'(rx_ready), 32'd0);
        check_eq("end words", 32'(words_loaded), valid ? 32'(n) : 32'd0);
    endtask

    initial begin
        bq_t s;
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        step();
        step();
        rst = 1'b0;
        check_reset();

        // Fixed two-word image, good checksum, then bad checksum.
        s = '{8'h02, 8'h30, 8'h00, 8'h8C, 8'h08, 8'hB6};
        start_load();
        send_stream(s, 0, 1'b0, -1);
        check_eq("img1 last data", 32'(mem_wdata), 32'h8C08);
        s = '{8'h02, 8'h30, 8'h00, 8'h8C, 8'h08, 8'hB7};
        start_load();
        send_stream(s, 0, 1'b0, -1);
        start_load();
        send_stream(make_stream(2, 1'b0), 0, 1'b0, -1);

        // Illegal counts, including a random one above the limit.
        s = '{8'h00};
        start_load();
        send_stream(s, 0, 1'b0, -1);
        s = '{8'h21};
        start_load();
        send_stream(s, 0, 1'b0, -1);
        s = '{8'($urandom_range(33, 255))};
        start_load();
        send_stream(s, 2, 1'b0, -1);

        // Timeout: exactly TOUT idle cycles after the last accepted byte.
        start_load();
        drive_byte(8'h01, 1'b0, 1'b0, 6'd0, 16'd0, 0);
        drive_byte(8'h30, 1'b0, 1'b0, 6'd0, 16'd0, 0);
        for (int i = 1; i <= TOUT; i++) begin
            step();
            check_eq("tout mem_we", 32'(mem_we), 32'd0);
            check_eq("tout error", 32'(error), (i == TOUT) ? 32'd1 : 32'd0);
        end
        check_eq("tout err_code", 32'(err_code), 32'd3);
        check_eq("tout hold", 32'(cpu_hold), 32'd1);
        check_eq("tout words", 32'(words_loaded), 32'd0);

        // Full region with random gaps and ignored start pulses.
        start_load();
        send_stream(make_stream(MAXW, 1'b0), 5, 1'b1, -1);

        // Random images, some with corrupted checksum.
        for (int r = 0; r < 8; r++) begin
            start_load();
            send_stream(make_stream($urandom_range(1, MAXW), ($urandom_range(0, 3) == 0)),
                        3, 1'b1, -1);
        end

        // Reset in the middle of a five-word load, then a clean load.
        start_load();
        send_stream(make_stream(5, 1'b0), 2, 1'b0, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();
        start_load();
        send_stream(make_stream(5, 1'b0), 2, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
- Loads a user program into the 64-word code memory's user region from an external byte stream, one 16-bit word at a time.
- Drives the code memory write port (write_enable / write_addr / write_data).
- Holds the CPU stalled while a load is in progress.
- Validates the image with a length byte and an XOR checksum.
- Sits between the host/UART receiver and the code memory, alongside the CPU core.

Parameters:
- BASE_ADDR, 32, first code-memory word written (start of user region).
- MAX_WORDS, 32, largest legal word count; BASE_ADDR+MAX_WORDS must be <= 64.
- TIMEOUT, 65535, consecutive idle cycles tolerated between bytes before abort; counter is 16 bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte this cycle
- mem_we  out  1  code memory write_enable
- mem_waddr  out  6  code memory write_addr
- mem_wdata  out  16  code memory write_data
- cpu_hold  out  1  stall/hold CPU fetch
- busy  out  1  load in progress
- done  out  1  last load completed and verified
- error  out  1  last load aborted
- err_code  out  2  01 bad count, 10 checksum mismatch, 11 timeout, 00 none
- words_loaded  out  6  words written in current/last load

Behaviour:
- Reset values: all outputs 0, except mem_waddr = BASE_ADDR. State = IDLE, so the CPU runs the existing image.
- Byte accepted on a rising edge when rx_valid && rx_ready. Throughput is one byte per cycle.
- Stream format:
  - COUNT byte N.
  - N pairs of HI, LO bytes; word = {HI, LO}.
  - CSUM byte = XOR of N and all data bytes.
- States: IDLE, COUNT, HI, LO, CSUM, DONE, ERR.
- rx_ready = 1 only in COUNT/HI/LO/CSUM. busy = same. done = 1 only in DONE. error = 1 only in ERR.
- IDLE/DONE/ERR + start -> COUNT. On this transition:
  - clear words_loaded, running XOR, timeout counter, done, error, err_code;
  - cpu_hold <= 1.
- start in any other state is ignored.
- COUNT:
  - N == 0 or N > MAX_WORDS -> ERR, err_code 01.
  - Otherwise latch N, XOR <= N -> HI.
- HI: latch byte into upper half -> LO.
- LO, on accept:
  - next cycle mem_we = 1 for exactly one cycle;
  - mem_wdata = {HI, LO}; mem_waddr = BASE_ADDR + words_loaded (pre-increment value);
  - words_loaded increments in that same cycle;
  - -> HI if more words remain, else -> CSUM.
- mem_waddr/mem_wdata hold their last values when mem_we = 0. mem_we is never asserted outside a valid LO accept.
- CSUM:
  - byte == running XOR -> DONE, cpu_hold <= 0;
  - else -> ERR, err_code 10.
  - Words already written stay in memory; no rollback.
- Timeout:
  - counter resets on every accepted byte and on entry to COUNT;
  - increments each cycle in COUNT/HI/LO/CSUM with no accept;
  - TIMEOUT consecutive non-accept cycles -> ERR, err_code 11.
  - An accept in the same cycle as expiry wins.
- ERR: cpu_hold stays 1 until the next start or rst. err_code holds.
- DONE: cpu_hold 0; done, words_loaded, err_code = 00 hold.
- Address never wraps; the last possible write is BASE_ADDR+MAX_WORDS-1 (63 by default).
- rst mid-load returns all state and outputs to reset values immediately (next edge). Partially written memory is left as is.

Test Plan:
1. start; bytes 02,30,00,8C,08,B6 on consecutive cycles -> mem_we pulses at addr 32 data 0x3000 and addr 33 data 0x8C08; done=1, error=0, words_loaded=2, cpu_hold 1 during load then 0.
2. start; count 00, then separately count 21 (33) -> ERR, err_code 01, no mem_we, cpu_hold=1, rx_ready=0.
3. Scenario 1 stream with CSUM B7 -> two writes occur, ERR, err_code 10, cpu_hold stays 1; new start with a correct stream -> done=1, cpu_hold=0.
4. TIMEOUT=16; start; bytes 01,30 then rx_valid held 0 -> exactly 16 idle cycles later error=1, err_code 11, no mem_we.
5. count 20 (32), 64 data bytes with random rx_valid gaps (each < TIMEOUT) plus correct CSUM -> 32 writes to addrs 32..63 in order, no write outside that range, words_loaded=32; start pulses mid-load have no effect.
6. rst asserted after 3 words of a 5-word load -> next cycle all outputs at reset values, state IDLE; a subsequent full load completes normally from addr 32.
